// File: rtl/mbc_control_sequencer_pkg.sv
// Shared constants for the MBC instruction-cycle sequencer: opcodes, T-state indices,
// SC width and the per-opcode final T-state lookup.
package mbc_ctrl_pkg;

  localparam int SC_W = 4;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  localparam logic [SC_W-1:0] T0 = 4'd0;
  localparam logic [SC_W-1:0] T1 = 4'd1;
  localparam logic [SC_W-1:0] T2 = 4'd2;
  localparam logic [SC_W-1:0] T3 = 4'd3;
  localparam logic [SC_W-1:0] T4 = 4'd4;
  localparam logic [SC_W-1:0] T5 = 4'd5;
  localparam logic [SC_W-1:0] T6 = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_INTR = 2'd2
  } seq_state_t;

  function automatic logic [SC_W-1:0] last_t(input logic [2:0] opcode);
    case (opcode)
      OP_REG:         last_t = T3;
      OP_STA, OP_BUN: last_t = T4;
      OP_ISZ:         last_t = T6;
      default:        last_t = T5;
    endcase
  endfunction

endpackage

// File: rtl/mbc_control_sequencer_opcode_decoder.sv
// 3-to-8 one-hot decode of the latched opcode into the D0-D7 lines.
module opcode_decoder (
  input  logic [2:0] opcode,
  output logic [7:0] d
);

  always_comb begin
    d = 8'd1 << opcode;
  end

endmodule

// File: rtl/mbc_control_sequencer.sv
// MBC instruction-cycle sequencer: SC, start/stop flip-flop, T0-T15 and D0-D7 generation.
// Define MBC_INTERRUPT_EN to compile in the three-cycle interrupt (R) cycle.
module mbc_control_sequencer
  import mbc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ir_i,
  input  logic [2:0]  ir_opcode,
  input  logic [11:0] ir_low,
  input  logic        mem_wait,
  input  logic        ien,
  input  logic        fgi,
  input  logic        fgo,
  output logic [15:0] t,
  output logic [7:0]  d,
  output logic        i_flag,
  output logic        running,
  output logic        halted,
  output logic        instr_done,
  output logic        r_cycle
);

  seq_state_t      state;
  logic [SC_W-1:0] sc;
  logic [2:0]      op_q;
  logic            i_q;
  logic            halted_q;
  logic            final_t;
  logic            hlt_hit;
  logic            irq_req;
  logic            unused_bits;

  assign final_t = (state == ST_RUN) && (sc == last_t(op_q));
  assign hlt_hit = (op_q == OP_REG) && !i_q && ir_low[0];

`ifdef MBC_INTERRUPT_EN
  assign irq_req     = ien & (fgi | fgo);
  assign r_cycle     = (state == ST_INTR);
  assign unused_bits = ^ir_low[11:1];
`else
  assign irq_req     = 1'b0;
  assign r_cycle     = 1'b0;
  assign unused_bits = ^{ir_low[11:1], ien, fgi, fgo};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sc       <= T0;
      op_q     <= OP_AND;
      i_q      <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            sc       <= T0;
            halted_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!mem_wait) begin
            // IR is stable by T2, so its fields are captured on leaving T2
            if (sc == T2) begin
              op_q <= ir_opcode;
              i_q  <= ir_i;
            end
            if (final_t) begin
              sc <= T0;
              if (hlt_hit) begin
                state    <= ST_IDLE;
                halted_q <= 1'b1;
              end else if (irq_req) begin
                state <= ST_INTR;
              end
            end else begin
              sc <= sc + SC_W'(1);
            end
          end
        end
        ST_INTR: begin
          if (!mem_wait) begin
            if (sc == T2) begin
              sc    <= T0;
              state <= ST_RUN;
            end else begin
              sc <= sc + SC_W'(1);
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          sc    <= T0;
        end
      endcase
    end
  end

  always_comb begin
    t = '0;
    if (state != ST_IDLE) t[sc] = 1'b1;
  end

  assign running    = (state != ST_IDLE);
  assign halted     = halted_q;
  assign i_flag     = i_q;
  assign instr_done = final_t;

  opcode_decoder u_dec (
    .opcode (op_q),
    .d      (d)
  );

endmodule
